memory_stage: RTL

MEMORY_STAGE -- requirements
Module: memory_stage

---
 rtl/y86_pkg.sv | 26 ++
 rtl/memory_stage_data_memory.sv | 36 +++
 rtl/memory_stage.sv | 97 +++++++++
 3 files changed

// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - shared y86 pipeline constants: stat codes, icodes, register ids
package y86_pkg;

    typedef enum logic [1:0] {
        STAT_AOK = 2'b00,
        STAT_HLT = 2'b01,
        STAT_ADR = 2'b10,
        STAT_INS = 2'b11
    } stat_e;

    localparam logic [3:0] I_NOP    = 4'h0;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] RNONE = 4'hF;

    // An 8-byte access fits when addr <= size-8; this form cannot wrap near 2^64.
    function automatic logic addr_in_range(input logic [63:0] addr, input int unsigned mem_bytes);
        return addr <= (64'(mem_bytes) - 64'd8);
    endfunction

endpackage

// File: rtl/memory_stage_data_memory.sv
// rtl/memory_stage_data_memory.sv - byte-array data memory, 8-byte little-endian comb read, sync write
module data_memory #(
    parameter int MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        i_we,
    input  logic [63:0] i_addr,
    input  logic [63:0] i_wdata,
    output logic [63:0] o_rdata
);
    localparam int AW = $clog2(MEM_BYTES);

    logic [7:0]    r_mem [MEM_BYTES];
    logic [AW-1:0] w_base;
    logic          w_unused_addr;

    // Callers gate out-of-range accesses, so only the low address bits matter here.
    assign w_base        = i_addr[AW-1:0];
    assign w_unused_addr = ^i_addr[63:AW];

    always_comb begin
        o_rdata = '0;
        for (int k = 0; k < 8; k++) begin
            o_rdata[8*k +: 8] = r_mem[w_base + AW'(k)];
        end
    end

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int k = 0; k < 8; k++) begin
                r_mem[w_base + AW'(k)] <= i_wdata[8*k +: 8];
            end
        end
    end

endmodule

// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - y86 memory stage: address/control decode, status, W pipeline register
module memory_stage
    import y86_pkg::*;
#(
    parameter int MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  M_stat,
    input  logic [3:0]  M_icode,
    input  logic        M_Cnd,
    input  logic [63:0] M_valE,
    input  logic [63:0] M_valA,
    input  logic [3:0]  M_dstE,
    input  logic [3:0]  M_dstM,
    input  logic        W_stall,
    input  logic        W_bubble,
    output logic [63:0] m_valM,
    output logic [1:0]  m_stat,
    output logic [1:0]  W_stat,
    output logic [3:0]  W_icode,
    output logic [63:0] W_valE,
    output logic [63:0] W_valM,
    output logic [3:0]  W_dstE,
    output logic [3:0]  W_dstM
);
    logic [63:0] w_addr;
    logic        w_rd;
    logic        w_wr;
    logic        w_ok;
    logic        w_we;
    logic [63:0] w_rdata;
    logic        w_unused_cnd;

    logic [1:0]  r_stat;
    logic [3:0]  r_icode;
    logic [63:0] r_valE;
    logic [63:0] r_valM;
    logic [3:0]  r_dstE;
    logic [3:0]  r_dstM;

    assign w_unused_cnd = M_Cnd;

    always_comb begin
        w_addr = '0;
        w_rd   = 1'b0;
        w_wr   = 1'b0;
        case (M_icode)
            I_RMMOVQ, I_CALL, I_PUSHQ: begin w_addr = M_valE; w_wr = 1'b1; end
            I_MRMOVQ:                  begin w_addr = M_valE; w_rd = 1'b1; end
            I_RET, I_POPQ:             begin w_addr = M_valA; w_rd = 1'b1; end
            default: ;
        endcase
    end

    assign w_ok   = addr_in_range(w_addr, MEM_BYTES);
    assign m_stat = ((w_rd || w_wr) && !w_ok) ? STAT_ADR : M_stat;
    assign m_valM = (w_rd && w_ok) ? w_rdata : 64'd0;
    // A faulting instruction here or already in W must not disturb architectural memory.
    assign w_we   = w_wr && w_ok && (M_stat == STAT_AOK) && (r_stat == STAT_AOK) && !reset;

    data_memory #(
        .MEM_BYTES(MEM_BYTES)
    ) u_mem (
        .clk    (clk),
        .i_we   (w_we),
        .i_addr (w_addr),
        .i_wdata(M_valA),
        .o_rdata(w_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset || W_bubble) begin
            r_stat  <= STAT_AOK;
            r_icode <= I_NOP;
            r_valE  <= '0;
            r_valM  <= '0;
            r_dstE  <= RNONE;
            r_dstM  <= RNONE;
        end else if (!W_stall) begin
            r_stat  <= m_stat;
            r_icode <= M_icode;
            r_valE  <= M_valE;
            r_valM  <= m_valM;
            r_dstE  <= M_dstE;
            r_dstM  <= M_dstM;
        end
    end

    assign W_stat  = r_stat;
    assign W_icode = r_icode;
    assign W_valE  = r_valE;
    assign W_valM  = r_valM;
    assign W_dstE  = r_dstE;
    assign W_dstM  = r_dstM;

endmodule
